// File: rtl/polyphase_merge4_if.sv
// Bundle of the 4-phase input word handshake and the serial output stream.
interface polyphase_merge4_if #(
  parameter int BW = 11
);
  logic signed [BW-1:0] IN1;
  logic signed [BW-1:0] IN2;
  logic signed [BW-1:0] IN3;
  logic signed [BW-1:0] IN4;
  logic                 IN_VALID;
  logic                 IN_READY;
  logic signed [BW-1:0] OUT;
  logic                 OUT_VALID;
  logic                 SYNC;
  logic                 UNDERRUN;

  // Producer/consumer side: drives the phase word, observes the stream.
  modport master (
    output IN1, IN2, IN3, IN4, IN_VALID,
    input  IN_READY, OUT, OUT_VALID, SYNC, UNDERRUN
  );

  // Interleaver side.
  modport slave (
    input  IN1, IN2, IN3, IN4, IN_VALID,
    output IN_READY, OUT, OUT_VALID, SYNC, UNDERRUN
  );
endinterface

// File: rtl/polyphase_merge4.sv
// 4-to-1 polyphase interleaver: one word of four phase samples in, one
// sample per clock out in stream order IN1, IN3, IN2, IN4. A one-word hold
// buffer lets the producer run up to 3 cycles late without a bubble.
module polyphase_merge4 #(
  parameter int BW = 11
) (
  input  logic CLK,
  input  logic RES,
  polyphase_merge4_if.slave bus
);

  logic signed [BW-1:0] r_hold  [4];
  logic                 r_hold_full;
  logic signed [BW-1:0] r_shift [4];
  logic [1:0]           r_cnt;
  logic                 r_busy;
  logic signed [BW-1:0] r_out;
  logic                 r_out_valid;
  logic                 r_sync;
  logic                 r_underrun;

  logic signed [BW-1:0] w_in_word    [4];
  logic signed [BW-1:0] w_hold_next  [4];
  logic signed [BW-1:0] w_shift_next [4];
  logic                 w_hold_full_next;
  logic [1:0]           w_cnt_next;
  logic                 w_busy_next;
  logic                 w_accept;
  logic                 w_load_slot;

  // Incoming word rearranged into emission order (stream index 4n..4n+3).
  assign w_in_word[0] = bus.IN1;
  assign w_in_word[1] = bus.IN3;
  assign w_in_word[2] = bus.IN2;
  assign w_in_word[3] = bus.IN4;

  assign bus.IN_READY = ~RES & ~r_hold_full;
  assign w_accept     = bus.IN_VALID & bus.IN_READY;
  // The shifter can take a new word when idle or while showing its last sample.
  assign w_load_slot  = ~r_busy | (r_cnt == 2'd3);

  // Next-state of hold buffer and shifter, in load-priority order.
  always_comb begin
    w_hold_next      = r_hold;
    w_shift_next     = r_shift;
    w_hold_full_next = r_hold_full;
    w_cnt_next       = r_cnt;
    w_busy_next      = r_busy;
    if (w_load_slot && r_hold_full) begin
      // Pending word always goes first; IN_READY is low so nothing new arrives.
      w_shift_next     = r_hold;
      w_hold_full_next = 1'b0;
      w_busy_next      = 1'b1;
      w_cnt_next       = 2'd0;
    end else if (w_load_slot && w_accept) begin
      w_shift_next = w_in_word;
      w_busy_next  = 1'b1;
      w_cnt_next   = 2'd0;
    end else begin
      if (w_accept) begin
        w_hold_next      = w_in_word;
        w_hold_full_next = 1'b1;
      end
      if (r_busy && r_cnt != 2'd3) begin
        w_cnt_next = r_cnt + 2'd1;
      end else if (r_busy) begin
        w_busy_next = 1'b0;
      end
    end
  end

  // State and output registers; outputs show the sample chosen at this edge.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      for (int i = 0; i < 4; i++) begin
        r_hold[i]  <= '0;
        r_shift[i] <= '0;
      end
      r_hold_full <= 1'b0;
      r_cnt       <= 2'd0;
      r_busy      <= 1'b0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_sync      <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_hold      <= w_hold_next;
      r_shift     <= w_shift_next;
      r_hold_full <= w_hold_full_next;
      r_cnt       <= w_cnt_next;
      r_busy      <= w_busy_next;
      if (w_busy_next) begin
        r_out <= w_shift_next[w_cnt_next];
      end
      r_out_valid <= w_busy_next;
      r_sync      <= w_busy_next & (w_cnt_next == 2'd0);
      // Busy-to-idle transition marks the stream break.
      r_underrun  <= r_busy & ~w_busy_next;
    end
  end

  assign bus.OUT       = r_out;
  assign bus.OUT_VALID = r_out_valid;
  assign bus.SYNC      = r_sync;
  assign bus.UNDERRUN  = r_underrun;

endmodule

// File: tb/tb_polyphase_merge4.sv
// Randomized bench for polyphase_merge4 against a word-schedule model: each
// accepted word starts at max(accept edge, previous start + 4) and occupies
// four consecutive output cycles.
module tb_polyphase_merge4;
  localparam int BW = 11;

  logic clk;
  logic rst;

  polyphase_merge4_if #(.BW(BW)) bus ();

  polyphase_merge4 #(.BW(BW)) dut (
    .CLK(clk),
    .RES(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: per accepted word, accept edge, start edge, stream samples.
  int m_a[$];
  int m_s[$];
  int m_d[$];
  int m_last_out = 0;
  int edge_no    = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  function automatic bit model_ready(input int e);
    for (int i = 0; i < m_s.size(); i++)
      if (m_a[i] < e && e <= m_s[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Check what the outputs must be after edge e.
  task automatic check_outputs(input int e);
    int  val;
    bit  act;
    bit  sync;
    bit  und;
    act  = 1'b0;
    sync = 1'b0;
    und  = 1'b0;
    val  = m_last_out;
    for (int i = 0; i < m_s.size(); i++) begin
      if (m_s[i] <= e && e < m_s[i] + 4) begin
        act  = 1'b1;
        val  = m_d[4*i + (e - m_s[i])];
        sync = (e == m_s[i]);
      end
    end
    if (!act)
      for (int i = 0; i < m_s.size(); i++)
        if (m_s[i] + 4 == e) und = 1'b1;
    m_last_out = val;
    check_val("OUT_VALID", int'(bus.OUT_VALID), int'(act));
    check_val("OUT", int'(bus.OUT), val);
    check_val("SYNC", int'(bus.SYNC), int'(sync));
    check_val("UNDERRUN", int'(bus.UNDERRUN), int'(und));
  endtask

  // One clock: check previous edge's outputs, drive, take the edge.
  task automatic step(input bit valid, input int x[4], output bit acc);
    bit rdy;
    @(negedge clk);
    check_outputs(edge_no - 1);
    rdy = model_ready(edge_no);
    check_val("IN_READY", int'(bus.IN_READY), int'(rdy));
    bus.IN_VALID = valid;
    bus.IN1 = BW'(x[0]);
    bus.IN3 = BW'(x[1]);
    bus.IN2 = BW'(x[2]);
    bus.IN4 = BW'(x[3]);
    @(posedge clk);
    acc = valid && rdy;
    if (acc) begin
      int st;
      st = edge_no;
      if (m_s.size() > 0 && m_s[m_s.size()-1] + 4 > st) st = m_s[m_s.size()-1] + 4;
      m_a.push_back(edge_no);
      m_s.push_back(st);
      for (int k = 0; k < 4; k++) m_d.push_back(x[k]);
    end
    edge_no++;
  endtask

  // Present a word (x in stream order) until accepted, bounded.
  task automatic send_word(input int x[4]);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 16 && !acc; t++) step(1'b1, x, acc);
    if (!acc) check_val("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    int z[4];
    bit acc;
    z = '{0, 0, 0, 0};
    for (int t = 0; t < n; t++) step(1'b0, z, acc);
  endtask

  task automatic model_reset();
    m_a.delete();
    m_s.delete();
    m_d.delete();
    m_last_out = 0;
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(0, 2047)) - 1024;
  endfunction

  initial begin
    int w[4];
    rst = 1'b1;
    bus.IN_VALID = 1'b0;
    bus.IN1 = '0;
    bus.IN2 = '0;
    bus.IN3 = '0;
    bus.IN4 = '0;
    #1;
    check_val("rst_OUT", int'(bus.OUT), 0);
    check_val("rst_IN_READY", int'(bus.IN_READY), 0);
    check_val("rst_OUT_VALID", int'(bus.OUT_VALID), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Single word: IN1=1, IN3=2, IN2=3, IN4=4 -> stream 1,2,3,4.
    send_word('{1, 2, 3, 4});
    idle(7);

    // Back-to-back words.
    send_word('{0, 1, 2, 3});
    send_word('{4, 5, 6, 7});
    idle(10);

    // Producer gap of 6 cycles between accepts.
    send_word('{10, 11, 12, 13});
    idle(5);
    send_word('{14, 15, 16, 17});
    idle(6);

    // Signed extremes.
    send_word('{-1024, -1, 1023, 0});
    idle(6);

    // Async reset with the shifter at CNT=1 and hold full.
    send_word('{21, 22, 23, 24});
    send_word('{25, 26, 27, 28});
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_OUT", int'(bus.OUT), 0);
    check_val("arst_OUT_VALID", int'(bus.OUT_VALID), 0);
    check_val("arst_SYNC", int'(bus.SYNC), 0);
    check_val("arst_UNDERRUN", int'(bus.UNDERRUN), 0);
    check_val("arst_IN_READY", int'(bus.IN_READY), 0);
    bus.IN_VALID = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    send_word('{9, 9, 9, 9});
    idle(7);

    // Producer presents a word every cycle: 16 words.
    for (int n = 0; n < 16; n++) begin
      for (int k = 0; k < 4; k++) w[k] = rnd_sample();
      send_word(w);
    end
    idle(8);

    // Random producer jitter.
    for (int n = 0; n < 24; n++) begin
      for (int k = 0; k < 4; k++) w[k] = rnd_sample();
      send_word(w);
      idle(int'($urandom_range(0, 6)));
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
